// File: rtl/wb_slave_interface_pkg.sv
// Shared types and bus widths for the NIC WISHBONE slave.
// Beat payload layout and slave FSM state encoding.
package wb_slave_interface_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int GRAN  = 8;
    localparam int SEL_W = DAT_W / GRAN;
    localparam int TGA_W = 8;
    localparam int TGC_W = 4;

    localparam logic [TGC_W-1:0] CMD_READ  = 4'h1;
    localparam logic [TGC_W-1:0] CMD_WRITE = 4'h2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        FLUSH     = 2'd2,
        READ_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [TGA_W-1:0] tga;
        logic [TGC_W-1:0] tgc;
        logic             we;
        logic             last;
    } beat_t;

endpackage

// File: rtl/wb_beat_fifo.sv
// Synchronous beat FIFO for the TX queue path.
// Push at full is taken when a pop happens in the same cycle.
module wb_beat_fifo
    import wb_slave_interface_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  beat_t wdata,
    input  logic  pop,
    output beat_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    beat_t                 mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr;
    logic [DEPTH_LOG2:0]   rptr;
    logic                  do_pop;
    logic                  do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                     (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[DEPTH_LOG2-1:0]];

    // storage write, contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
    end

    // read/write pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_slave_interface.sv
// WISHBONE pipelined slave: bus cycles become beat messages for the NIC TX queue.
// Reads are registered in the on-the-fly table and answered by forwarded reply ACKs.
module wb_slave_interface
    import wb_slave_interface_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 7,
    parameter int FIFO_DEPTH_LOG2     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CYC_I,
    input  logic             STB_I,
    input  logic             WE_I,
    input  logic [ADR_W-1:0] ADR_I,
    input  logic [DAT_W-1:0] DAT_I,
    input  logic [SEL_W-1:0] SEL_I,
    input  logic [TGA_W-1:0] TGA_I,
    input  logic [TGC_W-1:0] TGC_I,
    output logic             ACK_O,
    output logic             ERR_O,
    output logic             RTY_O,
    output logic             STALL_O,
    input  logic             reply_ack_i,
    input  logic             reply_done_i,
    input  logic             table_full_i,
    output logic             insert_o,
    output logic             cancel_o,
    output logic             beat_valid_o,
    input  logic             beat_ready_i,
    output logic [ADR_W-1:0] beat_adr_o,
    output logic [DAT_W-1:0] beat_dat_o,
    output logic [SEL_W-1:0] beat_sel_o,
    output logic [TGA_W-1:0] beat_tga_o,
    output logic [TGC_W-1:0] beat_tgc_o,
    output logic             beat_we_o,
    output logic             beat_last_o
);

    localparam int CNT_W = N_BITS_BURST_LENGHT;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    beat_t            staged;
    beat_t            bus_beat;
    beat_t            push_beat;
    beat_t            fifo_rdata;
    beat_t            head;
    logic [CNT_W-1:0] cnt;
    logic             ack_r;
    logic             err_r;
    logic             rty_r;
    logic             accept;
    logic             push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             room;

    assign bus_beat = {ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, WE_I, 1'b0};
    assign fifo_pop = beat_ready_i & ~fifo_empty;
    assign room     = ~fifo_full | fifo_pop;
    assign accept   = CYC_I & STB_I & ~STALL_O;

    // stall: reads need a FIFO slot at once, writes need one for the staged beat
    always_comb begin
        STALL_O = 1'b1;
        unique case (state)
            IDLE:    STALL_O = CYC_I & STB_I & ~WE_I & ~room;
            WRITE:   STALL_O = ~room;
            default: STALL_O = 1'b1;
        endcase
    end

    // select which beat enters the FIFO this cycle
    always_comb begin
        push      = 1'b0;
        push_beat = staged;
        unique case (state)
            IDLE: begin
                if (accept && !WE_I && !table_full_i) begin
                    push           = 1'b1;
                    push_beat      = bus_beat;
                    push_beat.last = 1'b1;
                end
            end
            WRITE: begin
                if (accept && WE_I && cnt != CNT_MAX) push = 1'b1;
            end
            FLUSH: begin
                if (room) begin
                    push           = 1'b1;
                    push_beat.last = 1'b1;
                end
            end
            default: push = 1'b0;
        endcase
    end

    // slave FSM with registered terminations and table pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            staged   <= '0;
            cnt      <= '0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rty_r    <= 1'b0;
            insert_o <= 1'b0;
            cancel_o <= 1'b0;
        end else begin
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rty_r    <= 1'b0;
            insert_o <= 1'b0;
            cancel_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (WE_I) begin
                            staged <= bus_beat;
                            cnt    <= CNT_W'(1);
                            ack_r  <= 1'b1;
                            state  <= WRITE;
                        end else if (table_full_i) begin
                            rty_r <= 1'b1;
                        end else begin
                            insert_o <= 1'b1;
                            state    <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    if (!CYC_I) begin
                        state <= FLUSH;
                    end else if (accept) begin
                        if (!WE_I || cnt == CNT_MAX) begin
                            err_r <= 1'b1;
                        end else begin
                            staged <= bus_beat;
                            cnt    <= cnt + 1'b1;
                            ack_r  <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (room) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                READ_WAIT: begin
                    if (reply_done_i) begin
                        state <= IDLE;
                    end else if (!CYC_I) begin
                        cancel_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ACK_O = (state == READ_WAIT) ? (reply_ack_i & CYC_I) : ack_r;
    assign ERR_O = err_r;
    assign RTY_O = rty_r;

    wb_beat_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(push_beat),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign head         = fifo_empty ? '0 : fifo_rdata;
    assign beat_valid_o = ~fifo_empty;
    assign beat_adr_o   = head.adr;
    assign beat_dat_o   = head.dat;
    assign beat_sel_o   = head.sel;
    assign beat_tga_o   = head.tga;
    assign beat_tgc_o   = head.tgc;
    assign beat_we_o    = head.we;
    assign beat_last_o  = head.last;

endmodule

// File: tb/tb_wb_slave_interface.sv
// Directed bench for wb_slave_interface (burst counter 3 bits, FIFO depth 2).
// Popped beats are collected in a queue and compared with hand-computed values.
module tb_wb_slave_interface;
    import wb_slave_interface_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             CYC_I, STB_I, WE_I;
    logic [ADR_W-1:0] ADR_I;
    logic [DAT_W-1:0] DAT_I;
    logic [SEL_W-1:0] SEL_I;
    logic [TGA_W-1:0] TGA_I;
    logic [TGC_W-1:0] TGC_I;
    logic             ACK_O, ERR_O, RTY_O, STALL_O;
    logic             reply_ack_i, reply_done_i, table_full_i;
    logic             insert_o, cancel_o;
    logic             beat_valid_o, beat_ready_i;
    logic [ADR_W-1:0] beat_adr_o;
    logic [DAT_W-1:0] beat_dat_o;
    logic [SEL_W-1:0] beat_sel_o;
    logic [TGA_W-1:0] beat_tga_o;
    logic [TGC_W-1:0] beat_tgc_o;
    logic             beat_we_o, beat_last_o;

    int    passed = 0;
    int    total  = 0;
    beat_t q[$];
    logic  a, e, r;

    wb_slave_interface #(
        .N_BITS_BURST_LENGHT(3),
        .FIFO_DEPTH_LOG2    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CYC_I       (CYC_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ADR_I       (ADR_I),
        .DAT_I       (DAT_I),
        .SEL_I       (SEL_I),
        .TGA_I       (TGA_I),
        .TGC_I       (TGC_I),
        .ACK_O       (ACK_O),
        .ERR_O       (ERR_O),
        .RTY_O       (RTY_O),
        .STALL_O     (STALL_O),
        .reply_ack_i (reply_ack_i),
        .reply_done_i(reply_done_i),
        .table_full_i(table_full_i),
        .insert_o    (insert_o),
        .cancel_o    (cancel_o),
        .beat_valid_o(beat_valid_o),
        .beat_ready_i(beat_ready_i),
        .beat_adr_o  (beat_adr_o),
        .beat_dat_o  (beat_dat_o),
        .beat_sel_o  (beat_sel_o),
        .beat_tga_o  (beat_tga_o),
        .beat_tgc_o  (beat_tgc_o),
        .beat_we_o   (beat_we_o),
        .beat_last_o (beat_last_o)
    );

    always #5 clk = ~clk;

    // collect beats the TX side pops; sampled well before the rising edge
    always begin
        @(negedge clk);
        #3;
        if (rst_n && beat_valid_o && beat_ready_i)
            q.push_back({beat_adr_o, beat_dat_o, beat_sel_o, beat_tga_o,
                         beat_tgc_o, beat_we_o, beat_last_o});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] last_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < q.size() && i < 16; i++) v[i] = q[i].last;
        return v;
    endfunction

    // one pipelined beat: hold until not stalled, return its termination
    task automatic bus(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [7:0] tga,
                       input logic [3:0] tgc,
                       output logic ack, output logic err, output logic rty);
        int n = 0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we;
        ADR_I = adr; DAT_I = dat; SEL_I = 4'hF; TGA_I = tga; TGC_I = tgc;
        #1;
        while (STALL_O && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("stall_bound", 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        ack = ACK_O; err = ERR_O; rty = RTY_O;
    endtask

    task automatic end_cycle();
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        CYC_I = 0; STB_I = 0; WE_I = 0;
        ADR_I = '0; DAT_I = '0; SEL_I = '0; TGA_I = '0; TGC_I = '0;
        reply_ack_i = 0; reply_done_i = 0; table_full_i = 0;
        beat_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs", {ACK_O, ERR_O, RTY_O, STALL_O, insert_o,
                           cancel_o, beat_valid_o, beat_last_o}, 0);
        chk("reset_dat", beat_dat_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4-beat write burst with the TX side always ready
        q.delete();
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 32'h100 + i, 32'hA000_0000 + i, 8'd1, CMD_WRITE, a, e, r);
            chk($sformatf("t1_term%0d", i), {a, e, r}, 3'b100);
        end
        end_cycle();
        drain();
        chk("t1_count", q.size(), 4);
        chk("t1_last", last_vec(), 16'h0008);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_dat%0d", i), q[i].dat, 32'hA000_0000 + i);

        // 5-beat write into the depth-2 FIFO with TX blocked
        q.delete();
        beat_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(1'b1, 32'h200 + i, 32'hB000_0000 + i, 8'd2, CMD_WRITE, a, e, r);
            chk($sformatf("t2_term%0d", i), {a, e, r}, 3'b100);
        end
        STB_I = 1'b1; DAT_I = 32'hB000_0003; ADR_I = 32'h203;
        #1;
        chk("t2_stall", STALL_O, 1'b1);
        beat_ready_i = 1'b1;
        for (int i = 3; i < 5; i++) begin
            bus(1'b1, 32'h200 + i, 32'hB000_0000 + i, 8'd2, CMD_WRITE, a, e, r);
            chk($sformatf("t2_term%0d", i), {a, e, r}, 3'b100);
        end
        end_cycle();
        drain();
        chk("t2_count", q.size(), 5);
        chk("t2_last", last_vec(), 16'h0010);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_dat%0d", i), q[i].dat, 32'hB000_0000 + i);

        // read with free table: insert, two forwarded ACKs, done
        q.delete();
        bus(1'b0, 32'h0000_1200, 32'h0, 8'd3, CMD_READ, a, e, r);
        chk("t3_term", {a, e, r}, 3'b000);
        chk("t3_insert", insert_o, 1'b1);
        STB_I = 1'b0;
        #1;
        chk("t3_stall", STALL_O, 1'b1);
        @(negedge clk);
        chk("t3_insert_pulse", insert_o, 1'b0);
        reply_ack_i = 1'b1;
        #1;
        chk("t3_ack1", ACK_O, 1'b1);
        @(negedge clk);
        reply_ack_i = 1'b0;
        #1;
        chk("t3_ack_gap", ACK_O, 1'b0);
        @(negedge clk);
        reply_ack_i = 1'b1;
        #1;
        chk("t3_ack2", ACK_O, 1'b1);
        @(negedge clk);
        reply_ack_i = 1'b0;
        reply_done_i = 1'b1;
        @(negedge clk);
        reply_done_i = 1'b0;
        #1;
        chk("t3_idle", STALL_O, 1'b0);
        end_cycle();
        drain();
        chk("t3_count", q.size(), 1);
        chk("t3_beat", {q[0].adr, q[0].tga, q[0].tgc, q[0].we, q[0].last},
            {32'h0000_1200, 8'd3, CMD_READ, 1'b0, 1'b1});

        // read with full table: retry, nothing stored
        q.delete();
        table_full_i = 1'b1;
        bus(1'b0, 32'h0000_1300, 32'h0, 8'd4, CMD_READ, a, e, r);
        chk("t4_term", {a, e, r}, 3'b001);
        chk("t4_insert", insert_o, 1'b0);
        end_cycle();
        table_full_i = 1'b0;
        drain();
        chk("t4_count", q.size(), 0);

        // 8-beat write: counter max is 7, eighth beat errors
        q.delete();
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, 32'h300 + i, 32'hC000_0000 + i, 8'd5, CMD_WRITE, a, e, r);
            chk($sformatf("t5_term%0d", i), {a, e, r},
                (i < 7) ? 3'b100 : 3'b010);
        end
        end_cycle();
        drain();
        chk("t5_count", q.size(), 7);
        chk("t5_last", last_vec(), 16'h0040);
        chk("t5_final_dat", q[6].dat, 32'hC000_0006);

        // master abandons a pending read
        q.delete();
        bus(1'b0, 32'h0000_1400, 32'h0, 8'd6, CMD_READ, a, e, r);
        end_cycle();
        @(negedge clk);
        chk("t6_cancel", cancel_o, 1'b1);
        @(negedge clk);
        chk("t6_cancel_pulse", cancel_o, 1'b0);
        drain();

        // reply done in the same cycle the master leaves: no cancel
        bus(1'b0, 32'h0000_1500, 32'h0, 8'd7, CMD_READ, a, e, r);
        end_cycle();
        reply_done_i = 1'b1;
        @(negedge clk);
        reply_done_i = 1'b0;
        chk("t6_no_cancel", cancel_o, 1'b0);
        chk("t6_no_cancel_idle", STALL_O, 1'b0);
        drain();

        // reset in the middle of a write burst
        q.delete();
        beat_ready_i = 1'b0;
        bus(1'b1, 32'h600, 32'hD000_0000, 8'd8, CMD_WRITE, a, e, r);
        bus(1'b1, 32'h601, 32'hD000_0001, 8'd8, CMD_WRITE, a, e, r);
        chk("t7_pre_valid", beat_valid_o, 1'b1);
        rst_n = 1'b0;
        end_cycle();
        #1;
        chk("t7_reset_outs", {ACK_O, ERR_O, RTY_O, STALL_O, insert_o,
                              cancel_o, beat_valid_o, beat_last_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_ready_i = 1'b1;
        drain();
        chk("t7_count", q.size(), 0);
        chk("t7_valid", beat_valid_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
